instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles a fetch request waits for imem_ready before trapping.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 NextPCSrc  input  1  1 = take ALURes as next PC (branch/jump), 0 = PC+4.
REQ-006 ALURes  input  32  branch/jump target from execute.
REQ-007 Retire  input  1  one-cycle pulse: current instruction finished; advance PC.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  32  fetch address (equals PC).
REQ-010 imem_ready  input  1  imem_rdata valid this cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 Inst  output  32  registered instruction.
REQ-013 OpCode 7 / Funct3 3 / Funct7 7 / Rs1 5 / Rs2 5 / Rd 5  outputs  fields Inst[6:0], [14:12], [31:25], [19:15], [24:20], [11:7]; feed ControlUnit and register unit.
REQ-014 PC  output  32  address of the instruction in Inst.
REQ-015 PCInc  output  32  PC+4, modulo 2^32.
REQ-016 InstValid  output  1  Inst and fields are valid for execution.
REQ-017 Trap  output  1  sticky fault flag.
REQ-018 TrapCause  output  2  00 none, 01 misaligned target, 10 fetch timeout.
REQ-019 InstCount  output  32  retired-instruction counter.

Function
REQ-020 States: FETCH, HOLD, TRAP.
REQ-021 FETCH: imem_req=1, imem_addr=PC; wait counter increments each cycle imem_ready=0.
REQ-022 FETCH with imem_ready=1: Inst <= imem_rdata, InstValid <= 1, wait counter <= 0, go HOLD (Inst visible cycle after ready).
REQ-023 FETCH with wait counter reaching TIMEOUT and imem_ready=0: go TRAP, TrapCause <= 10; imem_ready on that same cycle takes priority (capture, no trap).
REQ-024 HOLD: imem_req=0, Inst and PC stable; Retire=0 holds state indefinitely.
REQ-025 HOLD with Retire=1: target = NextPCSrc ? {ALURes[31:1],1'b0} : PC+4; InstCount <= InstCount+1 (wraps at 2^32).
REQ-026 If target[1]=0: PC <= target, InstValid <= 0, go FETCH.
REQ-027 If target[1]=1: PC unchanged, InstValid <= 0, go TRAP, TrapCause <= 01; retirement still counted.
REQ-028 TRAP: imem_req=0, InstValid=0, Trap=1; exit only by rst; Retire and imem_ready ignored.
REQ-029 Retire outside HOLD is ignored (no PC change, no count).
REQ-030 PC+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000, no trap.
REQ-031 Fetch latency: minimum 2 cycles from entering FETCH to InstValid=1 (ready in first FETCH cycle).
REQ-032 Decoded field outputs are purely Inst slices; undefined opcodes are passed through unchanged.

Reset
REQ-033 rst=1 at any clock edge, any state (including mid-fetch or TRAP): PC <= RESET_VECTOR, state <= FETCH, Inst <= 32'h0000_0013 (NOP), InstValid <= 0, Trap <= 0, TrapCause <= 00, InstCount <= 0, wait counter <= 0.
REQ-034 During rst=1 cycle outputs reflect pre-reset registers; from first cycle after, imem_req=1 with imem_addr=RESET_VECTOR.

Verification
REQ-035 Reset, imem_ready=1 with rdata 32'h00500093 -> next cycle InstValid=1, OpCode=0010011, Rd=1, PC=0, PCInc=4.
REQ-036 HOLD, Retire with NextPCSrc=0, PC=0x10 -> PC=0x14, InstCount+1, imem_req=1 next cycle.
REQ-037 Retire with NextPCSrc=1, ALURes=0x0000_0101 -> PC=0x100 (bit0 cleared), no trap; ALURes=0x0000_0102 -> Trap=1, TrapCause=01, PC unchanged.
REQ-038 imem_ready held 0 for TIMEOUT cycles -> Trap=1, TrapCause=10, imem_req=0; later imem_ready=1 ignored.
REQ-039 PC=0xFFFF_FFFC, Retire, NextPCSrc=0 -> PC=0x0, no trap.
REQ-040 rst asserted mid-FETCH with wait counter=5, and again in TRAP -> all outputs at reset values, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/imem_if.sv
// Instruction-memory request/response channel between the fetch unit and memory.
interface imem_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: fetches one word per PC, holds it until retirement,
// then advances PC (sequential or branch target) with misalignment and timeout traps.
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NextPCSrc,
  input  logic [31:0] ALURes,
  input  logic        Retire,
  imem_if.master      imem,
  output logic [31:0] Inst,
  output logic [6:0]  OpCode,
  output logic [2:0]  Funct3,
  output logic [6:0]  Funct7,
  output logic [4:0]  Rs1,
  output logic [4:0]  Rs2,
  output logic [4:0]  Rd,
  output logic [31:0] PC,
  output logic [31:0] PCInc,
  output logic        InstValid,
  output logic        Trap,
  output logic [1:0]  TrapCause,
  output logic [31:0] InstCount
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] TRAP  = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  // The wait counter only ever needs to hold 0..TIMEOUT-1.
  localparam int          WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [WW-1:0] wait_cnt;
  logic [31:0]   target;

  assign PCInc = PC + 32'd4;

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    target = PCInc;
    if (NextPCSrc) target = ALURes & ~32'd1;
  end

  assign imem.req  = (state == FETCH);
  assign imem.addr = PC;
  assign Trap      = (state == TRAP);

  assign OpCode = Inst[6:0];
  assign Funct3 = Inst[14:12];
  assign Funct7 = Inst[31:25];
  assign Rs1    = Inst[19:15];
  assign Rs2    = Inst[24:20];
  assign Rd     = Inst[11:7];

  // NOTE: sequential state uses non-blocking assignments so all registers update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      PC        <= RESET_VECTOR;
      Inst      <= NOP;
      InstValid <= 1'b0;
      TrapCause <= CAUSE_NONE;
      InstCount <= 32'd0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        FETCH: begin
          // A response on the final wait cycle wins over the timeout.
          if (imem.ready) begin
            Inst      <= imem.rdata;
            InstValid <= 1'b1;
            wait_cnt  <= '0;
            state     <= HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            TrapCause <= CAUSE_TIMEOUT;
            state     <= TRAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (Retire) begin
            InstCount <= InstCount + 32'd1;
            InstValid <= 1'b0;
            if (target[1]) begin
              TrapCause <= CAUSE_MISALIGN;
              state     <= TRAP;
            end else begin
              PC    <= target;
              state <= FETCH;
            end
          end
        end
        TRAP: begin
          state <= TRAP;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch (default parameters).
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        NextPCSrc;
  logic [31:0] ALURes;
  logic        Retire;
  logic [31:0] Inst;
  logic [6:0]  OpCode;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [4:0]  Rs1, Rs2, Rd;
  logic [31:0] PC, PCInc;
  logic        InstValid, Trap;
  logic [1:0]  TrapCause;
  logic [31:0] InstCount;

  int checks   = 0;
  int failures = 0;

  imem_if imem ();

  instruction_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .NextPCSrc (NextPCSrc),
    .ALURes    (ALURes),
    .Retire    (Retire),
    .imem      (imem),
    .Inst      (Inst),
    .OpCode    (OpCode),
    .Funct3    (Funct3),
    .Funct7    (Funct7),
    .Rs1       (Rs1),
    .Rs2       (Rs2),
    .Rd        (Rd),
    .PC        (PC),
    .PCInc     (PCInc),
    .InstValid (InstValid),
    .Trap      (Trap),
    .TrapCause (TrapCause),
    .InstCount (InstCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fetch_now(input logic [31:0] word);
    imem.ready = 1'b1;
    imem.rdata = word;
    tick();
    imem.ready = 1'b0;
  endtask

  task automatic retire(input logic src, input logic [31:0] alu);
    Retire    = 1'b1;
    NextPCSrc = src;
    ALURes    = alu;
    tick();
    Retire    = 1'b0;
    NextPCSrc = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_pc"},     PC,                32'h0);
    check({pfx, "_inst"},   Inst,              32'h0000_0013);
    check({pfx, "_valid"},  {31'd0, InstValid}, 32'd0);
    check({pfx, "_trap"},   {31'd0, Trap},      32'd0);
    check({pfx, "_cause"},  {30'd0, TrapCause}, 32'd0);
    check({pfx, "_count"},  InstCount,         32'd0);
    check({pfx, "_req"},    {31'd0, imem.req},  32'd1);
    check({pfx, "_addr"},   imem.addr,         32'h0);
  endtask

  initial begin
    rst = 1'b0; NextPCSrc = 1'b0; ALURes = '0; Retire = 1'b0;
    imem.ready = 1'b0; imem.rdata = '0;
    tick();

    do_reset();
    check_reset_state("rst0");

    // First fetch with ready in the first FETCH cycle.
    fetch_now(32'h0050_0093);
    check("f0_valid",  {31'd0, InstValid}, 32'd1);
    check("f0_opcode", {25'd0, OpCode}, 32'b0010011);
    check("f0_rd",     {27'd0, Rd},     32'd1);
    check("f0_rs1",    {27'd0, Rs1},    32'd0);
    check("f0_funct3", {29'd0, Funct3}, 32'd0);
    check("f0_pc",     PC,     32'h0);
    check("f0_pcinc",  PCInc,  32'h4);
    check("f0_req",    {31'd0, imem.req}, 32'd0);

    // HOLD without Retire keeps everything stable.
    tick(3);
    check("hold_inst",  Inst, 32'h0050_0093);
    check("hold_valid", {31'd0, InstValid}, 32'd1);
    check("hold_count", InstCount, 32'd0);

    // Jump to 0x10.
    retire(1'b1, 32'h10);
    check("j10_pc",    PC, 32'h10);
    check("j10_count", InstCount, 32'd1);
    check("j10_valid", {31'd0, InstValid}, 32'd0);
    check("j10_addr",  imem.addr, 32'h10);

    // Retire while in FETCH is ignored.
    retire(1'b1, 32'h40);
    check("fret_pc",    PC, 32'h10);
    check("fret_count", InstCount, 32'd1);

    // A few wait cycles, then a branch-format word to exercise Funct7/Rs2.
    tick(2);
    fetch_now(32'hFE20_8EE3);
    check("f1_opcode", {25'd0, OpCode}, 32'h63);
    check("f1_funct7", {25'd0, Funct7}, 32'h7F);
    check("f1_rs2",    {27'd0, Rs2},    32'd2);
    check("f1_rs1",    {27'd0, Rs1},    32'd1);
    check("f1_rd",     {27'd0, Rd},     32'd29);
    check("f1_trap",   {31'd0, Trap},   32'd0);

    // Sequential advance 0x10 -> 0x14.
    retire(1'b0, 32'h0);
    check("seq_pc",    PC, 32'h14);
    check("seq_count", InstCount, 32'd2);
    check("seq_req",   {31'd0, imem.req}, 32'd1);

    // Odd target: bit 0 is cleared.
    fetch_now(32'h0000_0013);
    retire(1'b1, 32'h0000_0101);
    check("b101_pc",   PC, 32'h100);
    check("b101_trap", {31'd0, Trap}, 32'd0);

    // Target with bit 1 set traps, PC unchanged, retirement counted.
    fetch_now(32'h0000_0013);
    retire(1'b1, 32'h0000_0102);
    check("b102_trap",  {31'd0, Trap},      32'd1);
    check("b102_cause", {30'd0, TrapCause}, 32'd1);
    check("b102_pc",    PC, 32'h100);
    check("b102_count", InstCount, 32'd4);
    check("b102_valid", {31'd0, InstValid}, 32'd0);
    check("b102_req",   {31'd0, imem.req},  32'd0);

    // TRAP ignores ready and Retire.
    imem.ready = 1'b1; imem.rdata = 32'h1234_5678; Retire = 1'b1;
    tick(3);
    imem.ready = 1'b0; Retire = 1'b0;
    check("trap_count", InstCount, 32'd4);
    check("trap_valid", {31'd0, InstValid}, 32'd0);
    check("trap_inst",  Inst, 32'h0000_0013);
    check("trap_stay",  {31'd0, Trap}, 32'd1);

    // Reset out of TRAP.
    do_reset();
    check_reset_state("rst_trap");

    // Timeout: 15 idle cycles still fetching, the 16th traps.
    tick(15);
    check("to15_trap", {31'd0, Trap}, 32'd0);
    check("to15_req",  {31'd0, imem.req}, 32'd1);
    tick();
    check("to16_trap",  {31'd0, Trap},      32'd1);
    check("to16_cause", {30'd0, TrapCause}, 32'd2);
    check("to16_req",   {31'd0, imem.req},  32'd0);
    fetch_now(32'hDEAD_BEEF);
    check("to_late_valid", {31'd0, InstValid}, 32'd0);
    check("to_late_inst",  Inst, 32'h0000_0013);

    // Ready on the final wait cycle wins over the timeout.
    do_reset();
    tick(15);
    fetch_now(32'h0010_0113);
    check("edge_valid", {31'd0, InstValid}, 32'd1);
    check("edge_trap",  {31'd0, Trap},      32'd0);
    check("edge_rd",    {27'd0, Rd},        32'd2);

    // PC wrap: jump to 0xFFFF_FFFC then step by 4.
    retire(1'b1, 32'hFFFF_FFFC);
    check("wr_pc", PC, 32'hFFFF_FFFC);
    fetch_now(32'h0000_0013);
    check("wr_pcinc", PCInc, 32'h0);
    retire(1'b0, 32'h0);
    check("wr_pc0",   PC, 32'h0);
    check("wr_trap",  {31'd0, Trap}, 32'd0);
    check("wr_count", InstCount, 32'd2);

    // Reset mid-FETCH with wait counter at 5 clears the counter.
    tick(5);
    do_reset();
    check_reset_state("rst_mid");
    tick(15);
    check("mid15_trap", {31'd0, Trap}, 32'd0);
    tick();
    check("mid16_trap", {31'd0, Trap}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
